trace_capture_ctrl: RTL and testbench

Trigger-and-capture front end that feeds trace_buffer. It selects one tile's injected flit stream and writes every valid flit from that stream into the buffer while armed. On a mask/value trigger match it records the buffer slot of the trigger flit, captures a programmable number of post-trigger flits, then freezes. JTAG then reads a pre/post-trigger window around the event.

---
 rtl/trace_capture_ctrl.sv | 129 ++++++++++++
 tb/tb_trace_capture_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_ctrl.sv
// Trigger-and-capture front end for trace_buffer: selects one tile's flit stream,
// streams it into the buffer while armed, and freezes a window around a mask/value trigger.
module trace_capture_ctrl #(
   parameter int Fpay     = 32,
   parameter int Tile_num = 4,
   parameter int TB_SIZE  = 512,
   parameter int Aw       = $clog2(TB_SIZE)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [Tile_num*Fpay-1:0] flit_in,
   input  logic [Tile_num-1:0]      flit_wr,
   input  logic [Tile_num-1:0]      ip_select,
   input  logic                     arm,
   input  logic [Fpay-1:0]          trig_mask,
   input  logic [Fpay-1:0]          trig_value,
   input  logic [Aw-1:0]            post_count,
   output logic [Fpay-1:0]          tb_din,
   output logic                     tb_wr_en,
   output logic [Aw-1:0]            trig_idx,
   output logic [Aw-1:0]            wr_idx,
   output logic                     wrapped,
   output logic [1:0]               state,
   output logic                     done
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] ARMED = 2'b01;
   localparam logic [1:0] POST  = 2'b10;
   localparam logic [1:0] DONE  = 2'b11;

   logic [Fpay-1:0] tile_flit [Tile_num];
   logic [Fpay-1:0] sel_flit;
   logic            one_hot;
   logic            sel_valid;
   logic            hit;
   logic            capture;

   logic [1:0]      state_reg;
   logic [Fpay-1:0] tb_din_reg;
   logic            tb_wr_en_reg;
   logic [Aw-1:0]   trig_idx_reg;
   logic [Aw-1:0]   wr_idx_reg;
   logic            wrapped_reg;
   logic [Aw-1:0]   post_cnt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < Tile_num; gi++) begin : g_tile
         assign tile_flit[gi] = flit_in[gi*Fpay +: Fpay] & {Fpay{ip_select[gi]}};
      end
   endgenerate

   // Masked OR-mux is only meaningful for a one-hot select; sel_valid gates everything else.
   always_comb begin
      sel_flit = '0;
      for (int i = 0; i < Tile_num; i++) begin
         sel_flit = sel_flit | tile_flit[i];
      end
   end

   assign one_hot   = (ip_select != '0) && ((ip_select & (ip_select - Tile_num'(1))) == '0);
   assign sel_valid = one_hot && ((flit_wr & ip_select) != '0);
   assign hit       = sel_valid && ((sel_flit & trig_mask) == (trig_value & trig_mask));
   assign capture   = arm && sel_valid && ((state_reg == ARMED) || (state_reg == POST));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         tb_din_reg   <= '0;
         tb_wr_en_reg <= 1'b0;
         trig_idx_reg <= '0;
         wr_idx_reg   <= '0;
         wrapped_reg  <= 1'b0;
         post_cnt_reg <= '0;
      end else begin
         tb_wr_en_reg <= capture;
         if (capture) begin
            tb_din_reg <= sel_flit;
            wr_idx_reg <= wr_idx_reg + Aw'(1);
            if (wr_idx_reg == Aw'(TB_SIZE - 1)) begin
               wrapped_reg <= 1'b1;
            end
         end
         case (state_reg)
            IDLE: begin
               // wr_idx keeps following the buffer pointer, so only wrapped restarts here.
               if (arm) begin
                  state_reg   <= ARMED;
                  wrapped_reg <= 1'b0;
               end
            end
            ARMED: begin
               if (!arm) begin
                  state_reg <= IDLE;
               end else if (hit) begin
                  trig_idx_reg <= wr_idx_reg;
                  post_cnt_reg <= post_count;
                  state_reg    <= (post_count == '0) ? DONE : POST;
               end
            end
            POST: begin
               if (!arm) begin
                  state_reg <= IDLE;
               end else if (sel_valid) begin
                  post_cnt_reg <= post_cnt_reg - Aw'(1);
                  if (post_cnt_reg == Aw'(1)) begin
                     state_reg <= DONE;
                  end
               end
            end
            default: begin
               if (!arm) begin
                  state_reg <= IDLE;
               end
            end
         endcase
      end
   end

   assign tb_din   = tb_din_reg;
   assign tb_wr_en = tb_wr_en_reg;
   assign trig_idx = trig_idx_reg;
   assign wr_idx   = wr_idx_reg;
   assign wrapped  = wrapped_reg;
   assign state    = state_reg;
   assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl: a linear sequence of steps with hand-computed
// expectations and a negedge monitor collecting every buffer write.
module tb_trace_capture_ctrl;

   localparam int Fpay     = 32;
   localparam int Tile_num = 4;
   localparam int TB_SIZE  = 512;
   localparam int Aw       = 9;

   logic                     clk;
   logic                     reset;
   logic [Tile_num*Fpay-1:0] flit_in;
   logic [Tile_num-1:0]      flit_wr;
   logic [Tile_num-1:0]      ip_select;
   logic                     arm;
   logic [Fpay-1:0]          trig_mask;
   logic [Fpay-1:0]          trig_value;
   logic [Aw-1:0]            post_count;
   logic [Fpay-1:0]          tb_din;
   logic                     tb_wr_en;
   logic [Aw-1:0]            trig_idx;
   logic [Aw-1:0]            wr_idx;
   logic                     wrapped;
   logic [1:0]               state;
   logic                     done;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] wq [$];
   logic [31:0] exp_basic [9];

   trace_capture_ctrl #(
      .Fpay(Fpay), .Tile_num(Tile_num), .TB_SIZE(TB_SIZE), .Aw(Aw)
   ) dut (
      .clk(clk), .reset(reset), .flit_in(flit_in), .flit_wr(flit_wr),
      .ip_select(ip_select), .arm(arm), .trig_mask(trig_mask),
      .trig_value(trig_value), .post_count(post_count), .tb_din(tb_din),
      .tb_wr_en(tb_wr_en), .trig_idx(trig_idx), .wr_idx(wr_idx),
      .wrapped(wrapped), .state(state), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each write strobe lasts one cycle, so one negedge sample per write.
   always @(negedge clk) begin
      if (reset === 1'b1 && tb_wr_en === 1'b1) wq.push_back(tb_din);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] f);
      flit_in[1*Fpay +: Fpay] = f;
      flit_wr = 4'b0010;
      step();
      flit_wr = 4'b0000;
   endtask

   initial begin
      exp_basic = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h05, 32'hAA, 32'h06, 32'h07, 32'h08};
      reset = 1'b0; arm = 1'b1; flit_in = '0; flit_wr = '0; ip_select = 4'b0010;
      trig_mask = '1; trig_value = 32'hAA; post_count = 9'd3;

      // Reset held with strobes toggling
      for (int i = 0; i < 4; i++) begin
         flit_wr = (i % 2 == 0) ? 4'b1111 : 4'b0000;
         flit_in = {4{32'hAA}};
         step();
      end
      chk("rst_wr_en", tb_wr_en, 0);
      chk("rst_state", state, 0);
      chk("rst_din", tb_din, 0);
      chk("rst_trig_idx", trig_idx, 0);
      chk("rst_wr_idx", wr_idx, 0);
      chk("rst_wrapped", wrapped, 0);
      chk("rst_done", done, 0);

      // Released but not armed
      flit_wr = '0; arm = 1'b0; reset = 1'b1;
      step();
      send(32'h11); send(32'h22); send(32'hAA); step();
      chk("idle_writes", wq.size(), 0);
      chk("idle_state", state, 0);
      chk("idle_wr_idx", wr_idx, 0);

      // Basic window
      arm = 1'b1; step();
      chk("arm_state", state, 1);
      for (int i = 1; i <= 5; i++) send(32'(i));
      send(32'hAA);
      chk("trig_state", state, 2);
      chk("trig_idx", trig_idx, 5);
      send(32'h06); send(32'h07); send(32'h08);
      chk("post_done_state", state, 3);
      chk("post_done", done, 1);
      chk("last_wr_en", tb_wr_en, 1);
      chk("last_din", tb_din, 32'h08);
      send(32'h09);
      chk("done_no_write", tb_wr_en, 0);
      step();
      chk("basic_count", wq.size(), 9);
      for (int i = 0; i < 9; i++) chk("basic_data", wq[i], exp_basic[i]);
      chk("basic_wr_idx", wr_idx, 9);
      chk("basic_trig_idx", trig_idx, 5);
      chk("basic_wrapped", wrapped, 0);

      // Re-arm without dropping arm stays in DONE; 1-0-1 re-arms
      step(); step();
      chk("hold_done", state, 3);
      arm = 1'b0; step();
      chk("disarm_idle", state, 0);
      chk("disarm_done", done, 0);
      arm = 1'b1; step();
      chk("rearm_state", state, 1);
      chk("rearm_wrapped", wrapped, 0);

      // Disarm during POST
      wq.delete();
      post_count = 9'd4;
      send(32'hAA);
      chk("p2_state", state, 2);
      chk("p2_trig_idx", trig_idx, 9);
      send(32'h10);
      chk("p2_post", state, 2);
      arm = 1'b0;
      send(32'h11);
      chk("p2_abort_state", state, 0);
      send(32'h12); step();
      chk("p2_count", wq.size(), 2);
      chk("p2_wr_idx", wr_idx, 11);
      chk("p2_trig_hold", trig_idx, 9);

      // Arm rising together with a matching flit
      wq.delete();
      arm = 1'b1;
      send(32'hAA);
      chk("armrise_state", state, 1);
      chk("armrise_wr_en", tb_wr_en, 0);
      chk("armrise_wr_idx", wr_idx, 11);

      // Select filtering
      ip_select = 4'b0100;
      flit_in = {4{32'hAA}};
      flit_wr = 4'b1001;
      step(); step(); step();
      flit_wr = 4'b0000;
      chk("sel_single_wr_idx", wr_idx, 11);
      chk("sel_single_state", state, 1);
      ip_select = 4'b0110;
      flit_wr = 4'b0110;
      step(); step(); step();
      flit_wr = 4'b0000; step();
      chk("sel_multi_wr_idx", wr_idx, 11);
      chk("sel_multi_state", state, 1);
      chk("sel_count", wq.size(), 0);

      // Partial-mask trigger
      ip_select = 4'b0010; trig_mask = 32'h0000FF00; trig_value = 32'h00003400; post_count = 9'd1;
      send(32'h12345678);
      chk("pm_nomatch_state", state, 1);
      chk("pm_wr_idx", wr_idx, 12);
      send(32'hABCD34EF);
      chk("pm_match_state", state, 2);
      chk("pm_trig_idx", trig_idx, 12);
      send(32'h0);
      chk("pm_done_state", state, 3);
      chk("pm_final_wr_idx", wr_idx, 14);

      // Asynchronous reset during POST
      arm = 1'b0; step();
      arm = 1'b1; step();
      trig_mask = '0; post_count = 9'd5;
      send(32'h1);
      chk("ar_post", state, 2);
      flit_in[1*Fpay +: Fpay] = 32'h2; flit_wr = 4'b0010;
      step();
      flit_wr = 4'b0000;
      chk("ar_wr_en_before", tb_wr_en, 1);
      #2 reset = 1'b0;
      #1;
      chk("ar_wr_en", tb_wr_en, 0);
      chk("ar_state", state, 0);
      chk("ar_wr_idx", wr_idx, 0);
      chk("ar_din", tb_din, 0);
      step();
      reset = 1'b1; arm = 1'b0; step();
      chk("ar_release_wr_idx", wr_idx, 0);
      chk("ar_release_state", state, 0);

      // Wrap boundary
      wq.delete();
      trig_mask = '1; trig_value = 32'hAA; post_count = 9'd0;
      arm = 1'b1; step();
      for (int i = 0; i < 510; i++) send(32'h1000_0000 + 32'(i));
      chk("wrap_pre_wr_idx", wr_idx, 510);
      chk("wrap_pre_wrapped", wrapped, 0);
      chk("wrap_pre_state", state, 1);
      trig_mask = '0;
      send(32'hBEEF);
      chk("wrap_trig_idx", trig_idx, 510);
      chk("wrap_wr_idx", wr_idx, 511);
      chk("wrap_state", state, 3);
      chk("wrap_wrapped", wrapped, 0);
      step();
      chk("wrap_count", wq.size(), 511);

      arm = 1'b0; step();
      arm = 1'b1; step();
      chk("wrap2_arm_wrapped", wrapped, 0);
      post_count = 9'd1;
      send(32'hC0DE);
      chk("wrap2_trig_idx", trig_idx, 511);
      chk("wrap2_wr_idx", wr_idx, 0);
      chk("wrap2_wrapped", wrapped, 1);
      chk("wrap2_state", state, 2);
      send(32'hD00D);
      chk("wrap2_final_wr_idx", wr_idx, 1);
      chk("wrap2_final_state", state, 3);
      step();
      chk("wrap2_last_data", wq[wq.size()-1], 32'hD00D);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
